dlx_data_memory: RTL and testbench

DLX_DATA_MEMORY -- requirements
Module: dlx_data_memory

---
 rtl/dlx_data_memory.sv | 118 +++++++++++
 tb/tb_dlx_data_memory.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dlx_data_memory.sv
// dlx_data_memory
//   Word-addressed data memory for the DLX MEM stage. Accepts one read or
//   write per request cycle while idle. A read returns its word after a
//   programmable latency, and data_valid pulses once when the word arrives.
//   Misaligned, out-of-range and conflicting requests are dropped and flagged.
//
// Parameters
//   DATA_WIDTH      data word width
//   DATA_ADDR_WIDTH byte address width
//   MEM_DEPTH_LOG2  log2 of the number of words
//   BASE_ADDRESS    byte address of word 0 (word aligned)
//   READ_LATENCY    cycles from read accept to data_valid (1..7)
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset (control and outputs only)
//   data_rd_en  read request
//   data_wr_en  write request
//   data_addr   byte address of the request
//   data_write  write data
//   data_read   registered read data, held between data_valid pulses
//   data_valid  one-cycle pulse, data_read carries a new word
//   busy        read in flight; new requests are ignored
//   addr_error  one-cycle pulse for a rejected request
module dlx_data_memory #(
  parameter int                         DATA_WIDTH      = 32,
  parameter int                         DATA_ADDR_WIDTH = 32,
  parameter int                         MEM_DEPTH_LOG2  = 10,
  parameter logic [DATA_ADDR_WIDTH-1:0] BASE_ADDRESS    = 32'h0000_0000,
  parameter int                         READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       addr_error
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, READ_WAIT, RESPOND} state_t;

  state_t                      state, state_nxt;
  logic [2:0]                  wait_cnt, wait_cnt_nxt;
  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [DATA_ADDR_WIDTH-1:0]  offset;
  logic [MEM_DEPTH_LOG2-1:0]   index, rd_index, rd_src;
  logic                        idle, misaligned, out_of_range, conflict;
  logic                        reject, wr_ok, rd_ok;

  // Offset subtraction wraps, so addresses below BASE_ADDRESS land far out
  // of range and are rejected along with addresses past the top word.
  assign offset       = data_addr - BASE_ADDRESS;
  assign index        = offset[MEM_DEPTH_LOG2+1:2];
  assign misaligned   = |offset[1:0];
  assign out_of_range = (offset >> (MEM_DEPTH_LOG2 + 2)) != '0;
  assign conflict     = data_rd_en & data_wr_en;
  assign idle         = (state == IDLE);

  assign reject = idle & (data_rd_en | data_wr_en) & (misaligned | out_of_range | conflict);
  assign wr_ok  = idle & ~rst & data_wr_en & ~data_rd_en & ~misaligned & ~out_of_range;
  assign rd_ok  = idle & data_rd_en & ~data_wr_en & ~misaligned & ~out_of_range;

  assign busy = ~idle;

  // With READ_LATENCY=1 the word is fetched on the accept edge itself, before
  // rd_index has captured the request, so take the live index in that case.
  assign rd_src = idle ? index : rd_index;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      IDLE: begin
        if (rd_ok) begin
          wait_cnt_nxt = 3'(READ_LATENCY - 1);
          state_nxt    = (READ_LATENCY > 1) ? READ_WAIT : RESPOND;
        end
      end
      READ_WAIT: begin
        wait_cnt_nxt = wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) state_nxt = RESPOND;
      end
      RESPOND:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      data_read  <= '0;
      data_valid <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      data_valid <= (state_nxt == RESPOND);
      addr_error <= reject;
      // RESPOND always returns to IDLE, so this fires only on entry.
      if (state_nxt == RESPOND) data_read <= mem[rd_src];
    end
  end

  // Storage and captured read index (not reset)
  always_ff @(posedge clk) begin
    if (wr_ok) mem[index] <= data_write;
    if (rd_ok) rd_index   <= index;
  end

endmodule

// File: tb/tb_dlx_data_memory.sv
// Bench for dlx_data_memory: a READ_LATENCY=2 instance exercised from a
// vector table plus hand-built busy/reset sequences, and a READ_LATENCY=1
// instance for back-to-back read spacing.
module tb_dlx_data_memory;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en, wr_en;
  logic [31:0] addr, wdata, data_read;
  logic        data_valid, busy, addr_error;

  logic        rd1, wr1;
  logic [31:0] addr1, wdata1, data_read1;
  logic        dv1, busy1, err1;

  dlx_data_memory #(.READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .data_rd_en(rd_en), .data_wr_en(wr_en),
    .data_addr(addr), .data_write(wdata), .data_read(data_read),
    .data_valid(data_valid), .busy(busy), .addr_error(addr_error)
  );

  dlx_data_memory #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .data_rd_en(rd1), .data_wr_en(wr1),
    .data_addr(addr1), .data_write(wdata1), .data_read(data_read1),
    .data_valid(dv1), .busy(busy1), .addr_error(err1)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Every data_valid pulse consumes one expected word.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (sb.size() == 0) check("dv_unexpected", 32'(data_valid), 32'd0);
      else check("rd_data", data_read, sb.pop_front());
    end
  end

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic op(input string name, input logic r, input logic w,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic e, input logic [31:0] exp);
    logic [31:0] prev;
    int n;
    logic acc;
    prev = data_read;
    acc  = r & ~w & ~e;
    @(negedge clk);
    rd_en = r; wr_en = w; addr = a; wdata = wd;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    check({name, "_err"}, 32'(addr_error), 32'(e));
    check({name, "_busy"}, 32'(busy), 32'(acc));
    if (e) check({name, "_hold"}, data_read, prev);
    if (acc) sb.push_back(exp);
    wait_idle(name, n);
    if (acc) check({name, "_busy_len"}, n, L);
    @(posedge clk); #1;
    check({name, "_err_clr"}, 32'(addr_error), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rd_en = 0; wr_en = 0; addr = 0; wdata = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;

    vecs.push_back('{1'b0, 1'b1, 32'h10,        32'hCAFE_0001, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,        32'h0,         1'b0, 32'hCAFE_0001});
    vecs.push_back('{1'b1, 1'b0, 32'h12,        32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h1000,      32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h20,        32'h1234_5678, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h20,        32'hDEAD_BEEF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h20,        32'h0,         1'b0, 32'h1234_5678});
    vecs.push_back('{1'b0, 1'b1, 32'hFFC,       32'hAAAA_5555, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'hFFC,       32'h0,         1'b0, 32'hAAAA_5555});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'h0000_0011, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h1000,      32'h0000_0BAD, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h13,        32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0011});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,        32'h0,         1'b0, 32'hCAFE_0001});

    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_read, 32'h0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(addr_error), 32'd0);
    check("rst1_dv", 32'(dv1), 32'd0);
    check("rst1_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      op($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd,
         vecs[i].err, vecs[i].exp);

    // Write issued while a read is in flight is dropped silently.
    @(negedge clk);
    rd_en = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    rd_en = 1'b0;
    sb.push_back(32'hCAFE_0001);
    check("busy_acc", 32'(busy), 32'd1);
    @(negedge clk);
    wr_en = 1'b1; addr = 32'h10; wdata = 32'h0;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("busy_wr_err", 32'(addr_error), 32'd0);
    wait_idle("busy_wr", n);
    op("busy_wr_rd", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE_0001);

    // Reset one cycle after accept aborts the read; a write during reset is dropped.
    @(negedge clk);
    rd_en = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("abort_acc", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; addr = 32'h10; wdata = 32'h0;
    @(posedge clk); #1;
    check("abort_data", data_read, 32'h0);
    check("abort_dv", 32'(data_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(addr_error), 32'd0);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_dv", 32'(data_valid), 32'd0);
    end
    op("abort_rd", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE_0001);

    // Latency-1 instance: continuous read request, accepted every other edge.
    @(negedge clk);
    wr1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h5A5A_0001;
    @(posedge clk); #1;
    wr1 = 1'b0;
    @(negedge clk);
    rd1 = 1'b1; addr1 = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("l1_dv%0d", i), 32'(dv1), 32'((i % 2) == 0));
      check($sformatf("l1_busy%0d", i), 32'(busy1), 32'((i % 2) == 0));
      if ((i % 2) == 0) check($sformatf("l1_data%0d", i), data_read1, 32'h5A5A_0001);
    end
    rd1 = 1'b0;

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
